mem_port_arbiter: RTL and testbench

Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage) of the RV32E pipeline. Only one transaction is outstanding at a time. Data requests have priority over fetches. The block generates byte enables from the access size and detects misaligned data accesses.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_byte_lane_gen.sv | 34 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  // The data path is fixed at 32 bits for RV32E.
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned BE_W       = ARB_DATA_W / 8;
  // Wide enough for a MEM_LATENCY of up to 7.
  localparam int unsigned LAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    ERR_D
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_byte_lane_gen.sv
// Byte-lane steering for data accesses: enables, store replication and alignment check.
module mem_port_arbiter_byte_lane_gen
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]            size,
  input  logic [1:0]            addr_lo,
  input  logic [ARB_DATA_W-1:0] wdata,
  output logic [BE_W-1:0]       be,
  output logic [ARB_DATA_W-1:0] wdata_rep,
  output logic                  misaligned
);

  // Decode the access size. The reserved encoding 3 falls through to word.
  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the IF fetch and MEM load/store requesters.
// One transaction outstanding at a time; data requests win over fetches.
// Optional feature macro: ARB_FETCH_GUARD_EN (bounds consecutive data grants while a fetch waits).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [1:0]          d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  arb_state_t           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic              lane_misaligned;
  logic              pick_d;

  mem_port_arbiter_byte_lane_gen u_byte_lane_gen (
    .size       (d_size),
    .addr_lo    (d_addr[1:0]),
    .wdata      (d_wdata),
    .be         (lane_be),
    .wdata_rep  (lane_wdata),
    .misaligned (lane_misaligned)
  );

`ifdef ARB_FETCH_GUARD_EN
  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  logic [StW-1:0] starve_q, starve_d;
  logic           fetch_force;

  assign fetch_force = (starve_q == StW'(STARVE_LIMIT));
  // A saturated counter hands the next arbitration to a waiting fetch.
  assign pick_d      = d_req & ~(if_req & fetch_force);

  // Count consecutive data grants that left a fetch waiting.
  always_comb begin
    starve_d = starve_q;
    if (d_gnt) begin
      if (!if_req) begin
        starve_d = '0;
      end else if (!fetch_force) begin
        starve_d = starve_q + 1'b1;
      end
    end else if (if_gnt) begin
      starve_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_LIMIT;
  assign pick_d        = d_req;
`endif

  assign busy = (state_q != IDLE);

  // Arbitration, memory strobe and completion routing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        // Grants are held off while reset is asserted so every output reads 0.
        if (rst_n && pick_d) begin
          d_gnt = 1'b1;
          if (lane_misaligned) begin
            state_d = ERR_D;
          end else begin
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_be    = lane_be;
            mem_addr  = d_addr & ~ADDR_W'(3);
            mem_wdata = lane_wdata;
            state_d   = BUSY_D;
            cnt_d     = LAT_CNT_W'(MEM_LATENCY - 1);
          end
        end else if (rst_n && if_req) begin
          if_gnt   = 1'b1;
          mem_req  = 1'b1;
          mem_be   = '1;
          mem_addr = if_addr & ~ADDR_W'(3);
          state_d  = BUSY_I;
          cnt_d    = LAT_CNT_W'(MEM_LATENCY - 1);
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ERR_D: begin
        d_rvalid = 1'b1;
        d_err    = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (latency-1 and latency-3 instances).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_req, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_d_err;
  logic        l3_mem_req, l3_mem_we, l3_busy;
  logic [31:0] l3_if_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata;
  logic [3:0]  l3_mem_be;

  int n_cmp;
  int n_err;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)
  ) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(l3_if_gnt), .if_rvalid(l3_if_rvalid),
    .if_rdata(l3_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata), .d_err(l3_d_err),
    .mem_req(l3_mem_req), .mem_we(l3_mem_we), .mem_be(l3_mem_be), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(mem_rdata), .busy(l3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 2 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_size  = 2'd2;
    d_addr  = 32'h0000_0020;
    d_wdata = 32'h1234_5678;
    mem_rdata = 32'hFFFF_FFFF;
    repeat (2) next_cycle();
    #2;
    n_cmp++;
    if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err, mem_req, mem_we,
         mem_be, mem_addr, mem_wdata, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b/%b req=%b be=%h addr=%h busy=%b, want all 0",
               if_gnt, d_gnt, mem_req, mem_be, mem_addr, busy);
    end
    next_cycle();
    if_req = 1'b0;
    d_req  = 1'b0;
    rst_n  = 1'b1;
    next_cycle();
    #2;
    n_cmp++;
    if ({busy, mem_req, if_rvalid, d_rvalid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy=%b req=%b rv=%b/%b want 0000",
               busy, mem_req, if_rvalid, d_rvalid);
    end
  endtask

  task automatic test_fetch();
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    #2;
    n_cmp++;
    if ({if_gnt, d_gnt, mem_req, mem_we, busy} !== 5'b10100 || mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL fetch_grant: got gnt=%b dgnt=%b req=%b we=%b busy=%b addr=%h want 10100 100",
               if_gnt, d_gnt, mem_req, mem_we, busy, mem_addr);
    end
    next_cycle();
    if_req    = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #2;
    n_cmp++;
    if ({if_rvalid, d_rvalid, busy, if_gnt} !== 4'b1010 || if_rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL fetch_rvalid: got rv=%b drv=%b busy=%b gnt=%b data=%h want 1010 deadbeef",
               if_rvalid, d_rvalid, busy, if_gnt, if_rdata);
    end
    next_cycle();
    #2;
    n_cmp++;
    if ({busy, if_rvalid} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_done: got busy=%b rv=%b want 00", busy, if_rvalid);
    end
  endtask

  task automatic test_priority();
    next_cycle();
    if_req  = 1'b1;
    if_addr = 32'h0000_0104;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_size  = 2'd2;
    d_addr  = 32'h0000_0200;
    #2;
    n_cmp++;
    if ({d_gnt, if_gnt, mem_req, mem_we} !== 4'b1010 || mem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL prio_data_first: got d=%b i=%b req=%b we=%b addr=%h want 1010 200",
               d_gnt, if_gnt, mem_req, mem_we, mem_addr);
    end
    next_cycle();
    d_req     = 1'b0;
    mem_rdata = 32'h1111_2222;
    #2;
    n_cmp++;
    if ({d_rvalid, if_rvalid, if_gnt, d_err} !== 4'b1000 || d_rdata !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL prio_data_rvalid: got drv=%b irv=%b igt=%b err=%b data=%h want 1000 11112222",
               d_rvalid, if_rvalid, if_gnt, d_err, d_rdata);
    end
    next_cycle();
    #2;
    n_cmp++;
    if ({if_gnt, d_gnt, mem_req} !== 3'b101 || mem_addr !== 32'h104) begin
      n_err++;
      $display("FAIL prio_fetch_second: got i=%b d=%b req=%b addr=%h want 101 104",
               if_gnt, d_gnt, mem_req, mem_addr);
    end
    next_cycle();
    if_req    = 1'b0;
    mem_rdata = 32'h3333_4444;
    #2;
    n_cmp++;
    if ({if_rvalid, d_rvalid} !== 2'b10 || if_rdata !== 32'h3333_4444) begin
      n_err++;
      $display("FAIL prio_fetch_rvalid: got irv=%b drv=%b data=%h want 10 33334444",
               if_rvalid, d_rvalid, if_rdata);
    end
  endtask

  task automatic test_lanes();
    logic [1:0]  sz   [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    logic        we   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ad   [7] = '{32'h303, 32'h301, 32'h402, 32'h400, 32'h504, 32'h508, 32'h302};
    logic [31:0] wd   [7] = '{32'hFFFF_FF5A, 32'h0000_00C3, 32'hAAAA_1234, 32'h0000_BEEF,
                              32'h89AB_CDEF, 32'h0102_0304, 32'h0000_0000};
    logic [3:0]  ebe  [7] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b0100};
    logic [31:0] ewd  [7] = '{32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h1234_1234, 32'hBEEF_BEEF,
                              32'h89AB_CDEF, 32'h0102_0304, 32'h0000_0000};
    logic [31:0] eadr [7] = '{32'h300, 32'h300, 32'h400, 32'h400, 32'h504, 32'h508, 32'h300};
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      d_req   = 1'b1;
      d_we    = we[i];
      d_size  = sz[i];
      d_addr  = ad[i];
      d_wdata = wd[i];
      #2;
      n_cmp++;
      if ({d_gnt, mem_req, mem_we} !== {2'b11, we[i]} || mem_be !== ebe[i] ||
          mem_addr !== eadr[i] || (we[i] && mem_wdata !== ewd[i])) begin
        n_err++;
        $display("FAIL lane_%0d: got gnt=%b req=%b we=%b be=%b addr=%h wd=%h want be=%b addr=%h wd=%h",
                 i, d_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ebe[i], eadr[i], ewd[i]);
      end
      next_cycle();
      d_req = 1'b0;
      #2;
      n_cmp++;
      if ({d_rvalid, d_err, busy} !== 3'b101) begin
        n_err++;
        $display("FAIL lane_done_%0d: got rv=%b err=%b busy=%b want 101", i, d_rvalid, d_err, busy);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
    logic [31:0] ad [4] = '{32'h401, 32'h402, 32'h401, 32'h403};
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_size = sz[i];
      d_addr = ad[i];
      #2;
      n_cmp++;
      if ({d_gnt, mem_req, if_gnt} !== 3'b100) begin
        n_err++;
        $display("FAIL misalign_grant_%0d: got gnt=%b req=%b igt=%b want 100",
                 i, d_gnt, mem_req, if_gnt);
      end
      next_cycle();
      d_req = 1'b0;
      #2;
      n_cmp++;
      if ({d_rvalid, d_err, busy, mem_req} !== 4'b1110 || d_rdata !== 32'h0) begin
        n_err++;
        $display("FAIL misalign_err_%0d: got rv=%b err=%b busy=%b req=%b data=%h want 1110 0",
                 i, d_rvalid, d_err, busy, mem_req, d_rdata);
      end
      next_cycle();
      #2;
      n_cmp++;
      if ({busy, d_rvalid, d_err} !== 3'b000) begin
        n_err++;
        $display("FAIL misalign_idle_%0d: got busy=%b rv=%b err=%b want 000",
                 i, busy, d_rvalid, d_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_rv;
    exp_rv = 4'b1000;
    next_cycle();
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_size    = 2'd2;
    d_addr    = 32'h0000_0700;
    mem_rdata = 32'hCAFE_F00D;
    #2;
    n_cmp++;
    if ({l3_d_gnt, l3_mem_req} !== 2'b11 || l3_mem_addr !== 32'h700) begin
      n_err++;
      $display("FAIL lat3_grant: got gnt=%b req=%b addr=%h want 11 700",
               l3_d_gnt, l3_mem_req, l3_mem_addr);
    end
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      d_req = 1'b0;
      #2;
      n_cmp++;
      if (l3_d_rvalid !== exp_rv[k] || l3_busy !== 1'b1 ||
          (exp_rv[k] && l3_d_rdata !== 32'hCAFE_F00D)) begin
        n_err++;
        $display("FAIL lat3_cycle_%0d: got rv=%b busy=%b data=%h want rv=%b busy=1",
                 k, l3_d_rvalid, l3_busy, l3_d_rdata, exp_rv[k]);
      end
    end
    next_cycle();
    d_req  = 1'b1;
    d_addr = 32'h0000_0704;
    #2;
    n_cmp++;
    if (l3_d_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL lat3_regrant: got gnt=%b want 1", l3_d_gnt);
    end
    next_cycle();
    if_req = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({l3_if_gnt, l3_if_rvalid, l3_if_rdata, l3_d_gnt, l3_d_rvalid, l3_d_rdata, l3_d_err,
         l3_mem_req, l3_mem_we, l3_mem_be, l3_mem_addr, l3_mem_wdata, l3_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got gnt=%b/%b rv=%b req=%b busy=%b want all 0",
               l3_if_gnt, l3_d_gnt, l3_d_rvalid, l3_mem_req, l3_busy);
    end
    repeat (2) next_cycle();
    d_req  = 1'b0;
    if_req = 1'b0;
    rst_n  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++;
      if ({l3_d_rvalid, l3_if_rvalid, l3_busy} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_mid_quiet_%0d: got drv=%b irv=%b busy=%b want 000",
                 k, l3_d_rvalid, l3_if_rvalid, l3_busy);
      end
      next_cycle();
    end
    d_req  = 1'b1;
    d_addr = 32'h0000_0708;
    #2;
    n_cmp++;
    if ({l3_d_gnt, l3_mem_req} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_mid_idle_grant: got gnt=%b req=%b want 11", l3_d_gnt, l3_mem_req);
    end
    next_cycle();
    d_req = 1'b0;
    repeat (4) next_cycle();
  endtask

  task automatic test_starve_guard();
    logic [9:0] exp_fetch;
`ifdef ARB_FETCH_GUARD_EN
    exp_fetch = 10'b10_0001_0000;
`else
    exp_fetch = 10'b00_0000_0000;
`endif
    next_cycle();
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_size  = 2'd2;
    d_addr  = 32'h0000_0500;
    if_req  = 1'b1;
    if_addr = 32'h0000_0600;
    for (int i = 0; i < 10; i++) begin
      #2;
      n_cmp++;
      if ({if_gnt, d_gnt} !== {exp_fetch[i], ~exp_fetch[i]}) begin
        n_err++;
        $display("FAIL guard_slot_%0d: got if_gnt=%b d_gnt=%b want if_gnt=%b",
                 i, if_gnt, d_gnt, exp_fetch[i]);
      end
      next_cycle();
      #2;
      n_cmp++;
      if ({if_gnt, d_gnt, busy} !== 3'b001) begin
        n_err++;
        $display("FAIL guard_busy_%0d: got if_gnt=%b d_gnt=%b busy=%b want 001",
                 i, if_gnt, d_gnt, busy);
      end
      next_cycle();
    end
    d_req  = 1'b0;
    if_req = 1'b0;
    repeat (4) next_cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_lanes();
    test_misaligned();
    test_reset_mid();
    test_starve_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
